// File: rtl/cic_integrator_decim.sv
// cic_integrator_decim: N-stage integrator chain at input rate followed by a decimate-by-R sampler
module cic_integrator_decim #(
  parameter int IN_WIDTH = 16,
  parameter int N        = 3,
  parameter int R        = 4,
  parameter int WIDTH    = 22
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [IN_WIDTH-1:0] inData,
  input  logic                inValid,
  output logic [WIDTH-1:0]    outData,
  output logic                outValid
);
  localparam int CW = $clog2(R);
  logic [N-1:0][WIDTH-1:0] acc, nxt;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(R - 1);
  assign nxt[0] = acc[0] + {{(WIDTH - IN_WIDTH){inData[IN_WIDTH-1]}}, inData};
  // each stage adds the previous stage's pre-edge value, forming a pipelined chain
  for (genvar i = 1; i < N; i++) begin : g_int
    assign nxt[i] = acc[i] + acc[i-1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc      <= '0;
      cnt      <= '0;
      outData  <= '0;
      outValid <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= inValid && last;
      if (inValid) begin
        acc <= nxt;
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) outData <= nxt[N-1];
      end
    end
endmodule

// File: tb/tb_cic_integrator_decim.sv
// tb_cic_integrator_decim: four configurations of the integrator/decimator checked against a binomial-sum model
module tb_cic_integrator_decim;
  localparam int ND = 4;
  localparam int NN [ND] = '{3, 1, 1, 1};
  localparam int RR [ND] = '{4, 4, 4, 2};
  localparam int WW [ND] = '{22, 22, 18, 22};

  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, inValid = 1'b0;
  logic [15:0] inData = '0;
  logic [21:0] od0, od1, od3;
  logic [17:0] od2;
  logic [ND-1:0] ov;
  logic [63:0] act_d [ND];
  logic [63:0] exp_d [ND] = '{default: 64'd0};
  logic exp_v [ND] = '{default: 1'b0};
  logic prev_v [ND] = '{default: 1'b0};
  int q [$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  cic_integrator_decim #(.IN_WIDTH(16), .N(3), .R(4), .WIDTH(22)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .inData(inData), .inValid(inValid), .outData(od0), .outValid(ov[0]));
  cic_integrator_decim #(.IN_WIDTH(16), .N(1), .R(4), .WIDTH(22)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .inData(inData), .inValid(inValid), .outData(od1), .outValid(ov[1]));
  cic_integrator_decim #(.IN_WIDTH(16), .N(1), .R(4), .WIDTH(18)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .inData(inData), .inValid(inValid), .outData(od2), .outValid(ov[2]));
  cic_integrator_decim #(.IN_WIDTH(16), .N(1), .R(2), .WIDTH(22)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .inData(inData), .inValid(inValid), .outData(od3), .outValid(ov[3]));

  assign act_d[0] = 64'(od0);
  assign act_d[1] = 64'(od1);
  assign act_d[2] = 64'(od2);
  assign act_d[3] = 64'(od3);

  function automatic longint binom(input int a, input int b);
    longint c = 1;
    if (b > a) return 0;
    for (int i = 0; i < b; i++) c = c * (a - i) / (i + 1);
    return c;
  endfunction

  // N cascaded running sums equal a binomially weighted sum of all samples since restart
  function automatic logic [63:0] model_out(input int n, input int w);
    longint s = 0;
    int k = q.size();
    for (int j = 0; j < k; j++) s += longint'(q[j]) * binom(k - 1 - j, n - 1);
    return 64'(s) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic drive(input logic v, input int d, input logic c);
    @(negedge clk);
    inValid = v;
    inData  = 16'(d);
    clear   = c;
    @(posedge clk);
    #1;
    if (c) q.delete();
    else if (v) q.push_back(int'($signed(16'(d))));
    for (int i = 0; i < ND; i++) begin
      exp_v[i] = !c && v && (q.size() % RR[i] == 0);
      if (exp_v[i]) exp_d[i] = model_out(NN[i], WW[i]);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      vectors++;
      if (ov[i] !== 1'b0 || act_d[i] !== 64'd0) begin
        miscompares++;
        $display("FAIL reset dut%0d: outValid=%b outData=%0h, expected 0 0", i, ov[i], act_d[i]);
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ramp();
    drive(1'b0, 0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1, 1'b0);
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (ov[i] !== exp_v[i] || act_d[i] !== exp_d[i] || (ov[i] && prev_v[i])) begin
          miscompares++;
          $display("FAIL ramp dut%0d k=%0d: outValid=%b outData=%0h, expected %b %0h", i, k, ov[i], act_d[i], exp_v[i], exp_d[i]);
        end
        prev_v[i] = ov[i];
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32767, 1'b0);
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (ov[i] !== exp_v[i] || act_d[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL wrap dut%0d k=%0d: outValid=%b outData=%0h, expected %b %0h", i, k, ov[i], act_d[i], exp_v[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    drive(1'b0, 0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      drive(k % 2 == 0, -1, 1'b0);
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (ov[i] !== exp_v[i] || act_d[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL gaps dut%0d k=%0d: outValid=%b outData=%0h, expected %b %0h", i, k, ov[i], act_d[i], exp_v[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_clear_mid();
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 1, 1'b0);
    drive(1'b1, 1, 1'b0);
    drive(1'b1, 1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, 1, 1'b0);
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (ov[i] !== exp_v[i] || act_d[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL clear dut%0d k=%0d: outValid=%b outData=%0h, expected %b %0h", i, k, ov[i], act_d[i], exp_v[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 0, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 3, 1'b0);
    vectors++;
    if (ov[1] !== 1'b1 || act_d[1] !== 64'd12) begin
      miscompares++;
      $display("FAIL prereset dut1: outValid=%b outData=%0h, expected 1 c", ov[1], act_d[1]);
    end
    #2 reset = 1'b0;
    #1;
    q.delete();
    for (int i = 0; i < ND; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 64'd0;
      vectors++;
      if (ov[i] !== 1'b0 || act_d[i] !== 64'd0) begin
        miscompares++;
        $display("FAIL asyncreset dut%0d: outValid=%b outData=%0h, expected 0 0", i, ov[i], act_d[i]);
      end
    end
    @(negedge clk);
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1, 1'b0);
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (ov[i] !== exp_v[i] || act_d[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL postreset dut%0d k=%0d: outValid=%b outData=%0h, expected %b %0h", i, k, ov[i], act_d[i], exp_v[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < ND; i++) prev_v[i] = 1'b0;
    for (int k = 0; k < 80; k++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom), $urandom_range(0, 24) == 0);
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (ov[i] !== exp_v[i] || act_d[i] !== exp_d[i] || (ov[i] && prev_v[i])) begin
          miscompares++;
          $display("FAIL random dut%0d k=%0d: outValid=%b outData=%0h, expected %b %0h", i, k, ov[i], act_d[i], exp_v[i], exp_d[i]);
        end
        prev_v[i] = ov[i];
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_gaps();
    test_clear_mid();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
